// File: rtl/mc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mc_pkg : opcodes, state encoding and datapath select encodings  |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
package mc_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mc_wait_timer : memory wait-cycle counter with limit detect      |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
module mc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [7:0] C_LIMIT = 8'(WAIT_MAX - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (clear) begin
            r_count <= 8'd0;
        end else if (count && (r_count < C_LIMIT)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Expired marks the WAIT_MAX-th cycle spent waiting in the current state.
    assign expired = (r_count >= C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mc_ctrl : multicycle main control FSM for the MIPS-subset core  |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       trap,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    logic   r_trap;
    logic   w_wait_state;
    logic   w_expired;
    logic   w_timeout;
    logic   w_mem_req, w_mem_we, w_ir_we, w_pc_en, w_reg_we;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout    = w_wait_state && !mem_ack && w_expired;

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_wait_state || mem_ack),
        .count   (w_wait_state && !mem_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_trap  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT) r_trap <= 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        iord       = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_en    = 1'b0;
        pc_src     = PC_ALU;
        w_reg_we   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                alu_src_b = SRCB_FOUR;
                w_ir_we   = mem_ack;
                w_pc_en   = mem_ack;
                if (mem_ack)        w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM2;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
                if (mem_ack)        w_next = S_MEMWB;
                else if (w_timeout) w_next = S_HALT;
            end
            S_MEMWB: begin
                w_reg_we   = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                iord      = 1'b1;
                if (mem_ack)        w_next = S_FETCH;
                else if (w_timeout) w_next = S_HALT;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_we = 1'b1;
                reg_dst  = 1'b1;
                w_next   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                w_pc_en   = zero;
                w_next    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_we = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = PC_JUMP;
                w_pc_en = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_HALT;
        endcase
    end

    // Strobes are gated by rst_n so an asserted reset kills any access at once.
    assign mem_req = w_mem_req && rst_n;
    assign mem_we  = w_mem_we  && rst_n;
    assign ir_we   = w_ir_we   && rst_n;
    assign pc_en   = w_pc_en   && rst_n;
    assign reg_we  = w_reg_we  && rst_n;
    assign trap    = r_trap;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_mc_ctrl : directed self-checking bench for mc_ctrl           |
// | Rev 1.0 - initial release                                       |
// +-----------------------------------------------------------------+
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_we, iord, ir_we, pc_en;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       trap;
    logic [3:0] state;

    int n_pass = 0;
    int n_total = 0;
    int n_req_hi;

    mc_ctrl #(
        .WAIT_MAX (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .trap       (trap),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven 2 time units after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_mem_req", 8'(mem_req), 8'd0);
        chk("rst_trap", 8'(trap), 8'd0);
        rst_n = 1'b1; #1;
        chk("first_req", 8'(mem_req), 8'd1);
        chk("first_iord", 8'(iord), 8'd0);

        // R-type, zero-wait memory
        mem_ack = 1'b1; #1;
        chk("r_fetch_irwe", 8'(ir_we), 8'd1);
        chk("r_fetch_pcen", 8'(pc_en), 8'd1);
        cyc(); chk("r_decode", 8'(state), 8'd1);
        chk("r_decode_srcb", 8'(alu_src_b), 8'd3);
        cyc(); chk("r_exec", 8'(state), 8'd6);
        chk("r_exec_aluop", 8'(alu_op), 8'd2);
        chk("r_exec_regwe", 8'(reg_we), 8'd0);
        cyc(); chk("r_aluwb", 8'(state), 8'd7);
        chk("r_aluwb_regwe", 8'(reg_we), 8'd1);
        chk("r_aluwb_regdst", 8'(reg_dst), 8'd1);
        cyc(); chk("r_back_fetch", 8'(state), 8'd0);

        // lw with three wait cycles in MEMRD
        opcode = 6'b100011;
        cyc(); chk("lw_decode", 8'(state), 8'd1);
        cyc(); chk("lw_memadr", 8'(state), 8'd2);
        chk("lw_memadr_srcb", 8'(alu_src_b), 8'd2);
        mem_ack = 1'b0;
        cyc(); chk("lw_memrd", 8'(state), 8'd3);
        chk("lw_memrd_req", 8'(mem_req), 8'd1);
        chk("lw_memrd_iord", 8'(iord), 8'd1);
        cyc(); chk("lw_wait2", 8'(state), 8'd3);
        cyc(); chk("lw_wait3", 8'(state), 8'd3);
        mem_ack = 1'b1; #1;
        chk("lw_ack_req", 8'(mem_req), 8'd1);
        cyc(); chk("lw_memwb", 8'(state), 8'd4);
        chk("lw_memwb_m2r", 8'(mem_to_reg), 8'd1);
        chk("lw_memwb_regwe", 8'(reg_we), 8'd1);
        chk("lw_memwb_req", 8'(mem_req), 8'd0);
        cyc(); chk("lw_back_fetch", 8'(state), 8'd0);

        // beq taken then not taken
        opcode = 6'b000100;
        cyc(); cyc(); chk("beq1_state", 8'(state), 8'd8);
        zero = 1'b1; #1;
        chk("beq1_pcen", 8'(pc_en), 8'd1);
        chk("beq1_pcsrc", 8'(pc_src), 8'd1);
        chk("beq1_aluop", 8'(alu_op), 8'd1);
        cyc(); chk("beq1_fetch", 8'(state), 8'd0);
        cyc(); cyc(); chk("beq0_state", 8'(state), 8'd8);
        zero = 1'b0; #1;
        chk("beq0_pcen", 8'(pc_en), 8'd0);
        cyc(); chk("beq0_fetch", 8'(state), 8'd0);

        // j and addi
        opcode = 6'b000010;
        cyc(); cyc(); chk("j_state", 8'(state), 8'd11);
        chk("j_pcen", 8'(pc_en), 8'd1);
        chk("j_pcsrc", 8'(pc_src), 8'd2);
        cyc(); chk("j_fetch", 8'(state), 8'd0);
        opcode = 6'b001000;
        cyc(); cyc(); chk("addi_ex", 8'(state), 8'd9);
        cyc(); chk("addi_wb", 8'(state), 8'd10);
        chk("addi_wb_regwe", 8'(reg_we), 8'd1);
        chk("addi_wb_regdst", 8'(reg_dst), 8'd0);
        cyc(); chk("addi_fetch", 8'(state), 8'd0);

        // sw interrupted by reset in MEMWR
        opcode = 6'b101011;
        cyc(); cyc(); mem_ack = 1'b0;
        cyc(); chk("sw_memwr", 8'(state), 8'd5);
        chk("sw_memwr_we", 8'(mem_we), 8'd1);
        chk("sw_memwr_req", 8'(mem_req), 8'd1);
        rst_n = 1'b0; #1;
        chk("sw_rst_req", 8'(mem_req), 8'd0);
        chk("sw_rst_we", 8'(mem_we), 8'd0);
        chk("sw_rst_state", 8'(state), 8'd0);
        cyc(); rst_n = 1'b1; #1;
        chk("sw_rel_state", 8'(state), 8'd0);

        // fetch timeout: four FETCH cycles without ack, then HALT
        cyc(); cyc(); cyc();
        chk("to_still_fetch", 8'(state), 8'd0);
        chk("to_no_trap", 8'(trap), 8'd0);
        cyc(); chk("to_halt", 8'(state), 8'd12);
        chk("to_trap", 8'(trap), 8'd1);
        chk("to_halt_req", 8'(mem_req), 8'd0);
        rst_n = 1'b0; #1;
        chk("to_rst_trap", 8'(trap), 8'd0);
        rst_n = 1'b1;

        // ack arriving in the limit cycle wins
        cyc(); cyc(); cyc();
        mem_ack = 1'b1; #1;
        chk("lim_fetch", 8'(state), 8'd0);
        cyc(); chk("lim_decode", 8'(state), 8'd1);
        chk("lim_trap", 8'(trap), 8'd0);

        // illegal opcode traps and halts
        opcode = 6'b111111;
        cyc(); chk("ill_halt", 8'(state), 8'd12);
        chk("ill_trap", 8'(trap), 8'd1);
        n_req_hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (mem_req !== 1'b0 || state !== 4'd12) n_req_hi++;
        end
        chk("ill_held_halt", 8'(n_req_hi), 8'd0);
        rst_n = 1'b0; #1;
        rst_n = 1'b1; #1;
        chk("ill_rst_state", 8'(state), 8'd0);
        chk("ill_rst_trap", 8'(trap), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle main control unit for the CMPE200 MIPS-subset core. It sequences the shared datapath (PC, instruction register, register file, ALU, unified memory port) one micro-step per clock, driven by the 6-bit opcode. It handshakes with a variable-latency memory through a req/ack pair, so instruction fetch and load/store stall until memory responds. A wait timer traps a hung memory, and unknown opcodes trap into a halt state.

## Interface
Parameters:
- WAIT_MAX, 15: maximum cycles spent in one memory state without mem_ack before trapping (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag, valid in the BEQ state.
- mem_ack  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier; valid with mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_we  out  1  instruction register load.
- pc_en  out  1  PC load.
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- reg_we  out  1  register file write.
- reg_dst  out  1  destination: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- trap  out  1  sticky. Set on an illegal opcode or a memory timeout.
- state  out  4  current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12.
- Decoded opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010. Any other opcode is illegal.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_we and pc_en are asserted only in the cycle where mem_ack=1.
  - On ack go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEMADR
  - R → EXEC
  - beq → BEQ
  - addi → ADDIEX
  - j → JUMP
  - illegal → HALT, with trap set.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Hold until ack, then go to MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Hold until ack, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
- ALUWB: reg_we=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0 → FETCH.
- JUMP: pc_src=10, pc_en=1 → FETCH.
- HALT: absorbing. All strobes are 0 and trap=1 until rst_n asserts.
- Wait timer:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in one of those states without mem_ack.
  - If it reaches WAIT_MAX with mem_ack still 0, the next state is HALT and trap is set.
  - An ack arriving in the same cycle as the limit wins: normal transition, no trap.
- Unlisted outputs are 0 in every state.

## Timing
- Reset (asynchronous):
  - state=FETCH, trap=0, timer=0.
  - While rst_n=0, all strobes (mem_req, mem_we, ir_we, pc_en, reg_we) are forced to 0.
  - The first mem_req is issued in the first cycle after rst_n is released.
- Outputs are decoded from state. ir_we and pc_en in FETCH, and pc_en in BEQ, also depend combinationally on mem_ack and zero.
- mem_req stays high from state entry through the ack cycle inclusive. It drops in the following cycle unless the next state also requests memory.
- Cycles per instruction with zero-wait memory (ack in the first cycle): R=4, lw=5, sw=4, beq=3, addi=4, j=3. Each wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately. No partial register or memory write is completed after reset assertion.

## Structure
- Package mc_pkg holds:
  - opcode constants (OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - the state encoding;
  - the alu_op, alu_src_b and pc_src encodings.
- Sub-module mc_wait_timer holds the WAIT_MAX counter, with clear, count and expired ports.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset, then R-type (opcode=000000) with mem_ack tied 1 → states 0,1,6,7,0; reg_we=1, reg_dst=1 in ALUWB only; 4 cycles total.
- lw (100011), mem_ack delayed 3 cycles in MEMRD → mem_req held 4 cycles with iord=1; MEMWB drives mem_to_reg=1, reg_we=1; 8 cycles total.
- beq (000100) with zero=1, then again with zero=0 → pc_en=1, pc_src=01 in BEQ for the first; pc_en=0 for the second; back to FETCH both times.
- Illegal opcode 111111 → DECODE goes to HALT; trap=1; mem_req stays 0 for 20 cycles; rst_n pulse returns to FETCH with trap=0.
- WAIT_MAX=4, mem_ack held 0 in FETCH → HALT after 4 wait cycles, trap=1. Repeat with ack in exactly the limit cycle → DECODE, trap=0.
- rst_n asserted mid-MEMWR → mem_req and mem_we drop to 0 in the same cycle; state=0 after release.
